// File: rtl/switch_bank_pkg.sv
// Shared constants and helpers for the switch_toggle_bank front end.
// Edge-mode encodings and counter width sizing used by the top and per-channel debouncer.
package switch_bank_pkg;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_BOTH = 2;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: input synchroniser, debounce counter, debounced level and edge pulse.
// o_fire is the combinational "event this edge" flag so the owner can update on the same edge.
module switch_debounce
    import switch_bank_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int EDGE_MODE       = EDGE_FALL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_switch,
    output logic o_state,
    output logic o_event,
    output logic o_fire
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   event_q, event_d;
    logic                   sync;
    logic                   accept;
    logic                   edge_match;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_switch};
        cnt_d   = '0;
        state_d = state_q;
        accept  = 1'b0;
        // Any sample agreeing with the accepted level restarts the stability window.
        if (sync != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = sync;
                accept  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        edge_match = (EDGE_MODE == EDGE_BOTH)
                   || ((EDGE_MODE == EDGE_FALL) && !sync)
                   || ((EDGE_MODE == EDGE_RISE) && sync);
        event_d    = accept && edge_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            state_q <= 1'b1;
            event_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            event_q <= event_d;
        end
    end

    assign o_state = state_q;
    assign o_event = event_q;
    assign o_fire  = event_d;

endmodule

// File: rtl/switch_toggle_bank.sv
// N-channel push-button front end: debounced levels, edge pulses and per-channel LED toggle latches.
// Define SWITCH_BANK_LONGPRESS_EN to add the per-channel long-press pulse output.
module switch_toggle_bank
    import switch_bank_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int EDGE_MODE       = EDGE_FALL,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_switch,
    input  logic            i_clear,
    output logic [N_CH-1:0] o_led,
    output logic [N_CH-1:0] o_state,
    output logic [N_CH-1:0] o_event,
    output logic [N_CH-1:0] o_long_press
);

    logic [N_CH-1:0] fire;
    logic [N_CH-1:0] led_q, led_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        switch_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_switch(i_switch[g]),
            .o_state (o_state[g]),
            .o_event (o_event[g]),
            .o_fire  (fire[g])
        );
    end

    // Clear beats a coincident toggle; the event pulse itself is unaffected.
    always_comb begin
        led_d = i_clear ? '0 : (led_q ^ fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign o_led = led_q;

`ifdef SWITCH_BANK_LONGPRESS_EN
    localparam int               HOLD_W   = cnt_width(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q [N_CH];
    logic [HOLD_W-1:0] hold_d [N_CH];
    logic [N_CH-1:0]   long_q, long_d;

    // Hold counter saturates at the threshold so each hold yields a single pulse.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            hold_d[k] = '0;
            long_d[k] = 1'b0;
            if (!o_state[k]) begin
                hold_d[k] = (hold_q[k] == HOLD_MAX) ? hold_q[k] : hold_q[k] + 1'b1;
                long_d[k] = (hold_q[k] == HOLD_MAX - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                hold_q[k] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                hold_q[k] <= hold_d[k];
            end
            long_q <= long_d;
        end
    end

    assign o_long_press = long_q;
`else
    assign o_long_press = '0;
`endif

endmodule
